// File: rtl/kf_pkg.sv
// kf_pkg: shared definitions for the Kalman-filter covariance-prediction blocks.
//   dt_gen_state_t : FSM states of the dt power generator
//   DBL_WIDTH_DEF  : default operand width (IEEE-754 binary64)
//   FP_ZERO/FP_ONE : binary64 constants shared with the CMU blocks
//   FP_MUL_LAT     : default fp_multiplier latency (valid rise to finish)
package kf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } dt_gen_state_t;

    localparam int DBL_WIDTH_DEF = 64;

    localparam logic [63:0] FP_ZERO = 64'h0000_0000_0000_0000;
    localparam logic [63:0] FP_ONE  = 64'h3FF0_0000_0000_0000;

    localparam int FP_MUL_LAT = 4;

endpackage

// File: rtl/kf_dt_power_gen_if.sv
// kf_dt_power_gen_if: request/result bundle of the dt power generator.
//   start, dt          : request a new computation with time step dt
//   busy, done         : computation in flight / one-cycle completion pulse
//   delta_valid        : level, all six powers consistent
//   delta_t1..delta_t6 : dt^1 .. dt^6
// master = requester/consumer, slave = the generator.
interface kf_dt_power_gen_if #(
    parameter int DBL_WIDTH = 64
);
    logic                 start;
    logic [DBL_WIDTH-1:0] dt;
    logic                 busy;
    logic                 done;
    logic                 delta_valid;
    logic [DBL_WIDTH-1:0] delta_t1;
    logic [DBL_WIDTH-1:0] delta_t2;
    logic [DBL_WIDTH-1:0] delta_t3;
    logic [DBL_WIDTH-1:0] delta_t4;
    logic [DBL_WIDTH-1:0] delta_t5;
    logic [DBL_WIDTH-1:0] delta_t6;

    modport master (
        output start, dt,
        input  busy, done, delta_valid,
        input  delta_t1, delta_t2, delta_t3, delta_t4, delta_t5, delta_t6
    );

    modport slave (
        input  start, dt,
        output busy, done, delta_valid,
        output delta_t1, delta_t2, delta_t3, delta_t4, delta_t5, delta_t6
    );
endinterface

// File: rtl/fp_multiplier.sv
// fp_multiplier: multi-cycle IEEE-754 binary64 multiplier.
//   clk    : clock
//   valid  : a rising edge starts a multiply of a * b (operands sampled then)
//   finish : one-cycle pulse, LAT cycles after the valid rise (rise cycle = 1)
//   a, b   : operands
//   result : product, round-to-nearest-even; zero/subnormal inputs give a
//            signed zero, exponent overflow gives infinity, underflow zero
// There is no reset: a new valid rise always restarts the sequence, so any
// operation in flight when the requester is reset is simply superseded.
module fp_multiplier #(
    parameter int LAT = 4
) (
    input  logic        clk,
    input  logic        valid,
    output logic        finish,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] result
);
    logic        valid_q;
    logic        run;
    logic [3:0]  cnt;
    logic [63:0] a_r, b_r;

    assign finish = run && (cnt == 4'(LAT - 1));

    always_ff @(posedge clk) begin
        valid_q <= valid;
        if (valid && !valid_q) begin
            a_r <= a;
            b_r <= b;
            run <= 1'b1;
            cnt <= 4'd1;
        end else if (finish) begin
            run <= 1'b0;
        end else if (run) begin
            cnt <= cnt + 4'd1;
        end
    end

    // Product datapath, evaluated on the latched operands.
    logic         sgn;
    logic [10:0]  ea, eb;
    logic [105:0] prod;
    logic [12:0]  e_raw;
    logic [51:0]  frac;
    logic         guard, sticky, rnd;
    logic [62:0]  mag;

    always_comb begin
        sgn   = a_r[63] ^ b_r[63];
        ea    = a_r[62:52];
        eb    = b_r[62:52];
        prod  = {53'd0, 1'b1, a_r[51:0]} * {53'd0, 1'b1, b_r[51:0]};
        // Biased exponent sum plus normalisation carry, still offset by +1023.
        e_raw = {2'b0, ea} + {2'b0, eb} + {12'd0, prod[105]};
        if (prod[105]) begin
            frac   = prod[104:53];
            guard  = prod[52];
            sticky = |prod[51:0];
        end else begin
            frac   = prod[103:52];
            guard  = prod[51];
            sticky = |prod[50:0];
        end
        rnd = guard && (sticky || frac[0]);
        // A rounding carry out of the fraction bumps the exponent for free.
        mag = {e_raw[10:0] - 11'd1023, frac} + {62'd0, rnd};
        if (ea == 11'd0 || eb == 11'd0 || e_raw <= 13'd1023) begin
            result = {sgn, 63'd0};
        end else if (e_raw >= 13'd3070) begin
            result = {sgn, 11'h7FF, 52'd0};
        end else begin
            result = {sgn, mag};
        end
    end
endmodule

// File: rtl/kf_dt_power_gen.sv
// kf_dt_power_gen: computes dt^1..dt^6 for the CMU covariance blocks with a
// single shared fp_multiplier, sequencing five products delta_tk = dt*delta_t(k-1).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of kf_dt_power_gen_if (start/dt in; busy, done,
//                delta_valid, delta_t1..delta_t6 out)
module kf_dt_power_gen
    import kf_pkg::*;
#(
    parameter int DBL_WIDTH = DBL_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    kf_dt_power_gen_if.slave   bus
);
    dt_gen_state_t        state;
    logic [2:0]           k;
    logic [DBL_WIDTH-1:0] dt_r;
    logic [DBL_WIDTH-1:0] pw [1:6];
    logic                 busy, done, delta_valid;

    logic                 mul_valid;
    logic                 mul_finish;
    logic [DBL_WIDTH-1:0] mul_b;
    logic [DBL_WIDTH-1:0] mul_result;

    // Dropping valid in GAP gives the multiplier a fresh rise per product.
    assign mul_valid = (state == MUL);

    always_comb begin
        mul_b = pw[1];
        for (int i = 2; i <= 5; i++) begin
            if (k == 3'(i + 1)) mul_b = pw[i];
        end
    end

    fp_multiplier #(.LAT(FP_MUL_LAT)) u_mul (
        .clk    (clk),
        .valid  (mul_valid),
        .finish (mul_finish),
        .a      (dt_r),
        .b      (mul_b),
        .result (mul_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            k           <= 3'd2;
            dt_r        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            delta_valid <= 1'b0;
            for (int i = 1; i <= 6; i++) pw[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (bus.start) begin
                        dt_r        <= bus.dt;
                        pw[1]       <= bus.dt;
                        delta_valid <= 1'b0;
                        busy        <= 1'b1;
                        k           <= 3'd2;
                        state       <= MUL;
                    end
                end
                MUL: begin
                    if (mul_finish) begin
                        for (int i = 2; i <= 6; i++) begin
                            if (k == 3'(i)) pw[i] <= mul_result;
                        end
                        if (k == 3'd6) begin
                            // Outputs registered on entry so they line up with DONE.
                            done        <= 1'b1;
                            delta_valid <= 1'b1;
                            busy        <= 1'b0;
                            state       <= DONE;
                        end else begin
                            k     <= k + 3'd1;
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    state <= MUL;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.delta_valid = delta_valid;
    assign bus.delta_t1    = pw[1];
    assign bus.delta_t2    = pw[2];
    assign bus.delta_t3    = pw[3];
    assign bus.delta_t4    = pw[4];
    assign bus.delta_t5    = pw[5];
    assign bus.delta_t6    = pw[6];
endmodule

// File: tb/tb_kf_dt_power_gen.sv
// tb_kf_dt_power_gen: scoreboard bench for kf_dt_power_gen. Expected powers
// come from a real-valued reference (repeated double multiplication) pushed
// at each accepted start and compared when done pulses.
module tb_kf_dt_power_gen;
    localparam int LM = 4;

    logic clk;
    logic rst_n;

    kf_dt_power_gen_if #(.DBL_WIDTH(64)) bus ();

    kf_dt_power_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_err;
    int done_cnt;
    int exp_done;
    logic [5:0][63:0] sb [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0][63:0] pow_model(input logic [63:0] d);
        logic [5:0][63:0] r;
        real x, acc;
        x    = $bitstoreal(d);
        acc  = x;
        r[0] = d;
        for (int i = 1; i < 6; i++) begin
            acc  = acc * x;
            r[i] = $realtobits(acc);
        end
        return r;
    endfunction

    function automatic logic [5:0][63:0] outs();
        return {bus.delta_t6, bus.delta_t5, bus.delta_t4,
                bus.delta_t3, bus.delta_t2, bus.delta_t1};
    endfunction

    // Scoreboard check on every done pulse.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            logic [5:0][63:0] e, o;
            done_cnt++;
            if (sb.size() == 0) begin
                chk("sb_empty_at_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                o = outs();
                for (int i = 0; i < 6; i++)
                    chk($sformatf("delta_t%0d", i + 1), o[i], e[i]);
                chk("dv_at_done", {63'd0, bus.delta_valid}, 64'd1);
                chk("busy_at_done", {63'd0, bus.busy}, 64'd0);
            end
        end
    end

    task automatic start_run(input logic [63:0] d);
        @(negedge clk);
        bus.dt    = d;
        bus.start = 1'b1;
        sb.push_back(pow_model(d));
        exp_done++;
        @(negedge clk);
        bus.start = 1'b0;
        bus.dt    = {$urandom, $urandom};
        chk("busy_after_start", {63'd0, bus.busy}, 64'd1);
        chk("dv_after_start", {63'd0, bus.delta_valid}, 64'd0);
        chk("t1_after_start", bus.delta_t1, d);
    endtask

    task automatic wait_done();
        int lat;
        lat = 1;
        while (!bus.done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.done) begin
            chk("timeout_done", 64'd0, 64'd1);
        end else begin
            chk("latency", 64'(lat + 1), 64'(5 * LM + 6));
            @(negedge clk);
            chk("done_one_cycle", {63'd0, bus.done}, 64'd0);
            chk("dv_held", {63'd0, bus.delta_valid}, 64'd1);
            chk("busy_idle", {63'd0, bus.busy}, 64'd0);
        end
    endtask

    initial begin
        logic [5:0][63:0] o;
        int lat;
        n_chk = 0; n_err = 0; done_cnt = 0; exp_done = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.dt    = 64'h0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
        chk("rst_dv", {63'd0, bus.delta_valid}, 64'd0);
        o = outs();
        for (int i = 0; i < 6; i++) chk($sformatf("rst_t%0d", i + 1), o[i], 64'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        start_run(64'h3FE0_0000_0000_0000); wait_done();   // 0.5
        chk("half_t6_const", bus.delta_t6, 64'h3F90_0000_0000_0000);
        start_run(64'h4000_0000_0000_0000); wait_done();   // 2.0
        chk("two_t6_const", bus.delta_t6, 64'h4050_0000_0000_0000);
        start_run(64'h3FF1_9999_9999_999A); wait_done();   // 1.1
        start_run(64'hBFF8_0000_0000_0000); wait_done();   // -1.5
        start_run(64'h0); wait_done();                     // 0.0

        // Start hammered throughout busy and in the DONE cycle, dt changing.
        start_run(64'h4008_0000_0000_0000);
        lat = 1;
        while (!bus.done && lat < 200) begin
            bus.start = 1'b1;
            bus.dt    = {$urandom, $urandom};
            @(negedge clk);
            lat++;
        end
        if (!bus.done) chk("timeout_hammer", 64'd0, 64'd1);
        @(negedge clk);
        bus.start = 1'b0;
        chk("done_cycle_start_ignored", {63'd0, bus.busy}, 64'd0);
        @(negedge clk);
        chk("still_idle", {63'd0, bus.busy}, 64'd0);

        // Reset in the middle of the third product, then a clean 1.0 run.
        start_run(64'h4008_0000_0000_0000);
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        void'(sb.pop_back());
        exp_done--;
        #1;
        chk("midrst_busy", {63'd0, bus.busy}, 64'd0);
        chk("midrst_dv", {63'd0, bus.delta_valid}, 64'd0);
        o = outs();
        for (int i = 0; i < 6; i++) chk($sformatf("midrst_t%0d", i + 1), o[i], 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start_run(64'h3FF0_0000_0000_0000); wait_done();

        repeat (5) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("done_count", 64'(done_cnt), 64'(exp_done));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running exp finished");
        $fatal(1, "timeout");
    end
endmodule
